// File: rtl/ppu_fb_writer.sv
// ppu_fb_writer
// Takes the PPU 2-bit pixel stream, maps each pixel through the BG palette,
// and tags it with its raster address (row-major, WIDTH x HEIGHT). It buffers
// the writes so that framebuffer stalls do not stall the PPU, and drives a
// valid/ready write port. The port's valid/addr/data registers are the head
// slot of the buffer. A small circular store of FIFO_DEPTH-1 entries sits
// behind them, so the total occupancy is 0..FIFO_DEPTH.
module ppu_fb_writer #(
    parameter int WIDTH      = 160,
    parameter int HEIGHT     = 144,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        pixel_in,
    input  logic              pixel_valid,
    input  logic              frame_start,
    input  logic [7:0]        palette,
    output logic              fb_wr_valid,
    input  logic              fb_wr_ready,
    output logic [ADDR_W-1:0] fb_wr_addr,
    output logic [1:0]        fb_wr_data,
    output logic              frame_done,
    output logic              overflow
);

    // Backing store behind the head register
    localparam int BUF_D = FIFO_DEPTH - 1;
    localparam int PTR_W = (BUF_D > 1) ? $clog2(BUF_D) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(BUF_D - 1);
    localparam logic [OCC_W-1:0]  OCC_FULL  = OCC_W'(FIFO_DEPTH);

    // Shade lookup: index p selects palette[2p+1:2p]
    function automatic logic [1:0] map_shade(input logic [7:0] pal,
                                             input logic [1:0] idx);
        logic [1:0] shade;
        case (idx)
            2'd0:    shade = pal[1:0];
            2'd1:    shade = pal[3:2];
            2'd2:    shade = pal[5:4];
            2'd3:    shade = pal[7:6];
            default: shade = 2'b00;
        endcase
        return shade;
    endfunction

    // Circular pointer advance over the BUF_D backing entries
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == PTR_LAST) begin
            r = {PTR_W{1'b0}};
        end else begin
            r = p + PTR_W'(1);
        end
        return r;
    endfunction

    // State
    logic [ADDR_W-1:0] addr_cnt_r;
    logic [ADDR_W-1:0] buf_addr_r [BUF_D];
    logic [1:0]        buf_data_r [BUF_D];
    logic [PTR_W-1:0]  buf_rd_ptr_r;
    logic [PTR_W-1:0]  buf_wr_ptr_r;
    logic [CNT_W-1:0]  buf_cnt_r;

    // Combinational next-state
    logic              pop_s;
    logic              full_s;
    logic              push_s;
    logic              drop_s;
    logic [OCC_W-1:0]  occ_s;
    logic [ADDR_W-1:0] addr_in_s;
    logic [1:0]        shade_s;
    logic              buf_empty_s;
    logic              buf_we_s;
    logic              valid_nxt_s;
    logic [ADDR_W-1:0] head_addr_nxt_s;
    logic [1:0]        head_data_nxt_s;
    logic [PTR_W-1:0]  rd_ptr_nxt_s;
    logic [PTR_W-1:0]  wr_ptr_nxt_s;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic [ADDR_W-1:0] addr_cnt_nxt_s;
    logic              overflow_nxt_s;
    logic              frame_done_nxt_s;

    // Input stage: handshake, full/drop decision, raster address, palette map
    always_comb begin
        pop_s       = fb_wr_valid & fb_wr_ready;
        occ_s       = OCC_W'(buf_cnt_r) + OCC_W'(fb_wr_valid);
        full_s      = (occ_s == OCC_FULL);
        push_s      = pixel_valid & (~full_s | pop_s);
        drop_s      = pixel_valid & full_s & ~pop_s;
        buf_empty_s = (buf_cnt_r == {CNT_W{1'b0}});
        shade_s     = map_shade(palette, pixel_in);
        if (frame_start) begin
            addr_in_s = {ADDR_W{1'b0}};
        end else begin
            addr_in_s = addr_cnt_r;
        end
        // Dropped pixels still consume an address so the raster stays aligned
        if (pixel_valid) begin
            if (addr_in_s == LAST_ADDR) begin
                addr_cnt_nxt_s = {ADDR_W{1'b0}};
            end else begin
                addr_cnt_nxt_s = addr_in_s + ADDR_W'(1);
            end
        end else if (frame_start) begin
            addr_cnt_nxt_s = {ADDR_W{1'b0}};
        end else begin
            addr_cnt_nxt_s = addr_cnt_r;
        end
        // A drop in the same cycle as frame_start keeps overflow set
        if (drop_s) begin
            overflow_nxt_s = 1'b1;
        end else if (frame_start) begin
            overflow_nxt_s = 1'b0;
        end else begin
            overflow_nxt_s = overflow;
        end
        frame_done_nxt_s = pop_s & (fb_wr_addr == LAST_ADDR);
    end

    // Buffer stage: refill the head register and steer pushes into the store
    always_comb begin
        valid_nxt_s     = fb_wr_valid;
        head_addr_nxt_s = fb_wr_addr;
        head_data_nxt_s = fb_wr_data;
        rd_ptr_nxt_s    = buf_rd_ptr_r;
        wr_ptr_nxt_s    = buf_wr_ptr_r;
        cnt_nxt_s       = buf_cnt_r;
        buf_we_s        = 1'b0;
        if (~fb_wr_valid | pop_s) begin
            // Head slot is free or being vacated this cycle
            if (~buf_empty_s) begin
                valid_nxt_s     = 1'b1;
                head_addr_nxt_s = buf_addr_r[buf_rd_ptr_r];
                head_data_nxt_s = buf_data_r[buf_rd_ptr_r];
                rd_ptr_nxt_s    = ptr_inc(buf_rd_ptr_r);
                if (push_s) begin
                    buf_we_s     = 1'b1;
                    wr_ptr_nxt_s = ptr_inc(buf_wr_ptr_r);
                end else begin
                    cnt_nxt_s = buf_cnt_r - CNT_W'(1);
                end
            end else if (push_s) begin
                // Empty store: bypass straight into the head register
                valid_nxt_s     = 1'b1;
                head_addr_nxt_s = addr_in_s;
                head_data_nxt_s = shade_s;
            end else begin
                valid_nxt_s = 1'b0;
            end
        end else begin
            // Head is stalled and held stable; new pixels queue behind it
            if (push_s) begin
                buf_we_s     = 1'b1;
                wr_ptr_nxt_s = ptr_inc(buf_wr_ptr_r);
                cnt_nxt_s    = buf_cnt_r + CNT_W'(1);
            end else begin
                cnt_nxt_s = buf_cnt_r;
            end
        end
    end

    // Head register, pointers, counters and status flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fb_wr_valid  <= 1'b0;
            fb_wr_addr   <= {ADDR_W{1'b0}};
            fb_wr_data   <= 2'b00;
            frame_done   <= 1'b0;
            overflow     <= 1'b0;
            addr_cnt_r   <= {ADDR_W{1'b0}};
            buf_rd_ptr_r <= {PTR_W{1'b0}};
            buf_wr_ptr_r <= {PTR_W{1'b0}};
            buf_cnt_r    <= {CNT_W{1'b0}};
        end else begin
            fb_wr_valid  <= valid_nxt_s;
            fb_wr_addr   <= head_addr_nxt_s;
            fb_wr_data   <= head_data_nxt_s;
            frame_done   <= frame_done_nxt_s;
            overflow     <= overflow_nxt_s;
            addr_cnt_r   <= addr_cnt_nxt_s;
            buf_rd_ptr_r <= rd_ptr_nxt_s;
            buf_wr_ptr_r <= wr_ptr_nxt_s;
            buf_cnt_r    <= cnt_nxt_s;
        end
    end

    // Backing store entries; written only when a push queues behind the head
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BUF_D; i++) begin
                buf_addr_r[i] <= {ADDR_W{1'b0}};
                buf_data_r[i] <= 2'b00;
            end
        end else if (buf_we_s) begin
            buf_addr_r[buf_wr_ptr_r] <= addr_in_s;
            buf_data_r[buf_wr_ptr_r] <= shade_s;
        end else begin
            buf_addr_r[buf_wr_ptr_r] <= buf_addr_r[buf_wr_ptr_r];
            buf_data_r[buf_wr_ptr_r] <= buf_data_r[buf_wr_ptr_r];
        end
    end

endmodule

// File: tb/tb_ppu_fb_writer.sv
// Testbench for ppu_fb_writer: palette vector table plus scoreboarded
// sequences for back-pressure, realign, a full frame and an asynchronous reset.
module tb_ppu_fb_writer;

    localparam int              AW    = 15;
    localparam logic [AW-1:0]   LAST  = 15'd23039;
    localparam int              DEPTH = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [1:0]    data;
    } wr_t;

    typedef struct {
        logic [7:0] pal;
        logic [1:0] pix;
        logic [1:0] exp_d;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [1:0]    pixel_in = 2'd0;
    logic          pixel_valid = 1'b0;
    logic          frame_start = 1'b0;
    logic [7:0]    palette = 8'hE4;
    logic          fb_wr_valid;
    logic          fb_wr_ready = 1'b0;
    logic [AW-1:0] fb_wr_addr;
    logic [1:0]    fb_wr_data;
    logic          frame_done;
    logic          overflow;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    // Reference model state
    wr_t           exp_q[$];
    int            occ_m = 0;
    logic [AW-1:0] addr_m = '0;
    logic          ovf_m = 1'b0;
    logic          done_m = 1'b0;

    vec_t vecs[12];

    ppu_fb_writer dut (
        .clk         (clk),
        .reset       (reset),
        .pixel_in    (pixel_in),
        .pixel_valid (pixel_valid),
        .frame_start (frame_start),
        .palette     (palette),
        .fb_wr_valid (fb_wr_valid),
        .fb_wr_ready (fb_wr_ready),
        .fb_wr_addr  (fb_wr_addr),
        .fb_wr_data  (fb_wr_data),
        .frame_done  (frame_done),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        occ_m  = 0;
        addr_m = '0;
        ovf_m  = 1'b0;
        done_m = 1'b0;
    endtask

    // One clock: drive inputs at the negedge, check the outputs against the model,
    // advance the model, then return just after the posedge.
    task automatic step(input logic pv, input logic [1:0] pix, input logic fs,
                        input logic [7:0] pal, input logic rdy, input logic [1:0] exp_d);
        logic          pop_m;
        logic          full_m;
        logic          drop_m;
        logic [AW-1:0] a_in;
        wr_t           e;
        @(negedge clk);
        pixel_valid = pv;
        pixel_in    = pix;
        frame_start = fs;
        palette     = pal;
        fb_wr_ready = rdy;
        chk("valid", {31'd0, fb_wr_valid}, {31'd0, occ_m != 0});
        chk("overflow", {31'd0, overflow}, {31'd0, ovf_m});
        chk("frame_done", {31'd0, frame_done}, {31'd0, done_m});
        if (frame_done === 1'b1) done_cnt++;
        pop_m  = (occ_m != 0) && rdy;
        done_m = 1'b0;
        if (occ_m != 0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty actual valid=1 expected no write at %0t", $time);
            end else begin
                e = exp_q[0];
                chk("wr_addr", {17'd0, fb_wr_addr}, {17'd0, e.addr});
                chk("wr_data", {30'd0, fb_wr_data}, {30'd0, e.data});
                if (pop_m) begin
                    void'(exp_q.pop_front());
                    done_m = (e.addr == LAST);
                end
            end
        end
        full_m = (occ_m == DEPTH);
        drop_m = pv && full_m && !pop_m;
        a_in   = fs ? '0 : addr_m;
        if (pv && !drop_m) begin
            exp_q.push_back('{addr: a_in, data: exp_d});
            occ_m++;
        end
        if (pop_m) occ_m--;
        if (drop_m) ovf_m = 1'b1;
        else if (fs) ovf_m = 1'b0;
        if (pv) addr_m = (a_in == LAST) ? '0 : a_in + 15'd1;
        else if (fs) addr_m = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 16 && occ_m != 0; i++) begin
            step(1'b0, 2'd0, 1'b0, 8'hE4, 1'b1, 2'd0);
        end
        step(1'b0, 2'd0, 1'b0, 8'hE4, 1'b1, 2'd0);
        chk("drain_idle", {31'd0, fb_wr_valid}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{8'hE4, 2'd0, 2'd0};
        vecs[1]  = '{8'hE4, 2'd1, 2'd1};
        vecs[2]  = '{8'hE4, 2'd2, 2'd2};
        vecs[3]  = '{8'hE4, 2'd3, 2'd3};
        vecs[4]  = '{8'h1B, 2'd0, 2'd3};
        vecs[5]  = '{8'h1B, 2'd1, 2'd2};
        vecs[6]  = '{8'h1B, 2'd2, 2'd1};
        vecs[7]  = '{8'h1B, 2'd3, 2'd0};
        vecs[8]  = '{8'h00, 2'd0, 2'd0};
        vecs[9]  = '{8'h00, 2'd3, 2'd0};
        vecs[10] = '{8'h93, 2'd0, 2'd3};
        vecs[11] = '{8'h93, 2'd3, 2'd2};

        #23 reset = 1'b1;
        model_reset();

        // Reset state
        chk("rst_valid", {31'd0, fb_wr_valid}, 32'd0);
        chk("rst_addr", {17'd0, fb_wr_addr}, 32'd0);
        chk("rst_data", {30'd0, fb_wr_data}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);

        // Palette vectors, one per cycle with ready high
        for (int i = 0; i < 12; i++) begin
            step(1'b1, vecs[i].pix, 1'b0, vecs[i].pal, 1'b1, vecs[i].exp_d);
            if (i == 0) begin
                chk("latency_valid", {31'd0, fb_wr_valid}, 32'd1);
                chk("latency_addr", {17'd0, fb_wr_addr}, 32'd0);
            end
        end
        drain();

        // Back-pressure: four queue, the fifth is dropped
        step(1'b1, 2'd0, 1'b1, 8'hE4, 1'b0, 2'd0);
        for (int i = 1; i < 4; i++) step(1'b1, 2'(i), 1'b0, 8'hE4, 1'b0, 2'(i));
        chk("bp_hold_valid", {31'd0, fb_wr_valid}, 32'd1);
        chk("bp_hold_addr", {17'd0, fb_wr_addr}, 32'd0);
        chk("bp_no_ovf_yet", {31'd0, overflow}, 32'd0);
        step(1'b1, 2'd0, 1'b0, 8'hE4, 1'b0, 2'd0);
        chk("bp_overflow", {31'd0, overflow}, 32'd1);
        chk("bp_still_addr0", {17'd0, fb_wr_addr}, 32'd0);
        step(1'b0, 2'd0, 1'b0, 8'hE4, 1'b0, 2'd0);
        drain();
        step(1'b1, 2'd1, 1'b0, 8'hE4, 1'b1, 2'd1);
        chk("bp_next_addr", {17'd0, fb_wr_addr}, 32'd5);

        // Realign after 100 pixels; overflow cleared by frame_start
        for (int i = 0; i < 100; i++) step(1'b1, 2'(i % 4), 1'b0, 8'hE4, 1'b1, 2'(i % 4));
        chk("realign_ovf_before", {31'd0, overflow}, 32'd1);
        step(1'b1, 2'd2, 1'b1, 8'hE4, 1'b1, 2'd2);
        chk("realign_addr0", {17'd0, fb_wr_addr}, 32'd0);
        chk("realign_ovf_clr", {31'd0, overflow}, 32'd0);
        step(1'b1, 2'd3, 1'b0, 8'hE4, 1'b1, 2'd3);
        chk("realign_addr1", {17'd0, fb_wr_addr}, 32'd1);
        drain();

        // Full frame from a frame_start, then wrap to address 0
        done_cnt = 0;
        step(1'b1, 2'd0, 1'b1, 8'hE4, 1'b1, 2'd0);
        for (int i = 1; i < 23040; i++) step(1'b1, 2'(i % 4), 1'b0, 8'hE4, 1'b1, 2'(i % 4));
        chk("frame_last_addr", {17'd0, fb_wr_addr}, 32'd23039);
        step(1'b1, 2'd1, 1'b0, 8'hE4, 1'b1, 2'd1);
        chk("frame_wrap_addr", {17'd0, fb_wr_addr}, 32'd0);
        chk("frame_done_now", {31'd0, frame_done}, 32'd1);
        drain();
        chk("frame_done_count", done_cnt, 32'd1);

        // Asynchronous reset while stalled with three entries queued
        for (int i = 0; i < 3; i++) step(1'b1, 2'(i), 1'b0, 8'hE4, 1'b0, 2'(i));
        step(1'b0, 2'd0, 1'b0, 8'hE4, 1'b0, 2'd0);
        chk("stall_valid", {31'd0, fb_wr_valid}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, fb_wr_valid}, 32'd0);
        chk("async_rst_addr", {17'd0, fb_wr_addr}, 32'd0);
        model_reset();
        fb_wr_ready = 1'b1;
        #20 reset = 1'b1;
        step(1'b1, 2'd3, 1'b0, 8'hE4, 1'b1, 2'd3);
        chk("post_rst_addr", {17'd0, fb_wr_addr}, 32'd0);
        chk("post_rst_data", {30'd0, fb_wr_data}, 32'd3);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
